sdram_port_arb: RTL and testbench

//   Shares the single 16-bit SDRAM controller port between the BIOS loader (hps_io ioctl, WIDE=1) and the V810 CPU bus.

---
 rtl/sdram_arb_pkg.sv | 22 ++
 rtl/sdram_arb_ldbuf.sv | 47 ++++
 rtl/sdram_port_arb.sv | 219 +++++++++++++++++++++
 tb/tb_sdram_port_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter (sdram_port_arb).
// Holds the arbiter state encoding, the default halfword address width and
// the byte-to-halfword address helper used by the loader path.
package sdram_arb_pkg;

    // Default SDRAM halfword address width (32 MB of 16-bit words)
    localparam int RAM_AW_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_WR,
        ST_CPU_LO,
        ST_CPU_HI,
        ST_CPU_ACK
    } arb_state_t;

    // Byte address to halfword address; bit 0 of the byte address is dropped
    function automatic logic [RAM_AW_DEF-1:0] hw_of(input logic [RAM_AW_DEF:0] byte_addr);
        return RAM_AW_DEF'(byte_addr >> 1);
    endfunction

endpackage

// File: rtl/sdram_arb_ldbuf.sv
// One-entry buffer between the hps_io loader and the SDRAM arbiter.
// A loader strobe fills the entry; it empties when the arbiter reports the
// SDRAM write complete. ld_wait mirrors occupancy, so it rises the cycle
// after the strobe and falls the cycle after the matching ram_ack.
// A strobe that arrives while the entry is full is dropped.
module sdram_arb_ldbuf
    import sdram_arb_pkg::*;
#(
    parameter int                RAM_AW  = RAM_AW_DEF,
    parameter logic [RAM_AW-1:0] LD_BASE = '0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ld_wr,
    input  logic [24:0]       ld_addr,
    input  logic [15:0]       ld_data,
    input  logic              ld_done,
    output logic              ld_full,
    output logic [RAM_AW-1:0] buf_addr,
    output logic [15:0]       buf_data,
    output logic              ld_wait
);

    // Occupancy flag: set by an accepted strobe, cleared by the write's completion
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ld_full <= 1'b0;
        end else if (ld_full) begin
            if (ld_done) begin
                ld_full <= 1'b0;
            end
        end else if (ld_wr) begin
            ld_full <= 1'b1;
        end
    end

    // Payload capture; only meaningful while ld_full is set, so it needs no reset
    always_ff @(posedge clk_sys) begin
        if (ld_wr && !ld_full) begin
            buf_addr <= LD_BASE + RAM_AW'(hw_of(ld_addr));
            buf_data <= ld_data;
        end
    end

    assign ld_wait = ld_full;

endmodule

// File: rtl/sdram_port_arb.sv
// Arbiter sharing the single 16-bit SDRAM controller port between the BIOS
// loader and the V810 CPU bus. Each 32-bit CPU access is split into a low
// and a high halfword op; halves with no byte enables are skipped.
// A buffered loader write wins in IDLE, but a CPU access already started
// always finishes both halves first. New CPU accesses are held off while
// the loader is active.
// Optional feature: define SDRAM_ARB_ROM_WP_EN to suppress CPU write halves
// landing in [ROM_BASE, ROM_BASE+ROM_HW); suppressed halves still count as
// complete so cpu_ack timing is unchanged.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int                RAM_AW   = RAM_AW_DEF,
    parameter logic [RAM_AW-1:0] LD_BASE  = RAM_AW'(24'h000000),
    parameter logic [RAM_AW-1:0] ROM_BASE = RAM_AW'(24'h000000),
    parameter logic [RAM_AW-1:0] ROM_HW   = RAM_AW'(24'h100000)
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    // loader (hps_io ioctl, 16-bit wide)
    input  logic              ld_active,
    input  logic              ld_wr,
    input  logic [24:0]       ld_addr,
    input  logic [15:0]       ld_data,
    output logic              ld_wait,
    // CPU bus
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [RAM_AW:0]   cpu_addr,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    // SDRAM controller
    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [1:0]        ram_be,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic              ram_ack
);

`ifdef SDRAM_ARB_ROM_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    arb_state_t        state;

    logic              ld_full;
    logic              ld_done;
    logic [RAM_AW-1:0] buf_addr;
    logic [15:0]       buf_data;

    logic [RAM_AW-1:0] req_hw_lo;
    logic [RAM_AW-1:0] req_hw_hi;
    logic              wp_lo;
    logic              wp_hi;
    logic              lo_need;
    logic              hi_need;
    logic              cpu_start;
    logic              hi_pend;

    // High-half context held for the second op of a split access
    logic              cur_we;
    logic [RAM_AW-1:0] cur_hw_hi;
    logic [1:0]        cur_be_hi;
    logic [15:0]       cur_wdata_hi;

    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr[1:0];

    // True when a halfword address falls inside the protected BIOS window
    function automatic logic in_rom(input logic [RAM_AW-1:0] hw);
        logic [RAM_AW-1:0] off;
        off = hw - ROM_BASE;
        return off < ROM_HW;
    endfunction

    sdram_arb_ldbuf #(
        .RAM_AW  (RAM_AW),
        .LD_BASE (LD_BASE)
    ) u_ldbuf (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ld_wr    (ld_wr),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_done  (ld_done),
        .ld_full  (ld_full),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .ld_wait  (ld_wait)
    );

    // The CPU halfword pair is always even/odd, so the high address never carries out
    assign req_hw_lo = {cpu_addr[RAM_AW:2], 1'b0};
    assign req_hw_hi = {cpu_addr[RAM_AW:2], 1'b1};

    assign wp_lo   = WP_EN && cpu_we && in_rom(req_hw_lo);
    assign wp_hi   = WP_EN && cpu_we && in_rom(req_hw_hi);
    assign lo_need = (|cpu_be[1:0]) && !wp_lo;
    assign hi_need = (|cpu_be[3:2]) && !wp_hi;

    assign cpu_start = (state == ST_IDLE) && !ld_full && cpu_req && !ld_active;
    assign ld_done   = (state == ST_LD_WR) && ram_ack;

    // Latch the high-half request context when a CPU access is accepted
    always_ff @(posedge clk_sys) begin
        if (cpu_start) begin
            cur_we       <= cpu_we;
            cur_hw_hi    <= req_hw_hi;
            cur_be_hi    <= cpu_be[3:2];
            cur_wdata_hi <= cpu_wdata[31:16];
        end
    end

    // Arbiter FSM; every SDRAM and CPU output is registered here
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_be    <= 2'b00;
            ram_wdata <= 16'h0000;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 32'h0000_0000;
            hi_pend   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ld_full) begin
                        state     <= ST_LD_WR;
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= buf_addr;
                        ram_be    <= 2'b11;
                        ram_wdata <= buf_data;
                    end else if (cpu_start) begin
                        cpu_rdata <= 32'h0000_0000;
                        hi_pend   <= hi_need;
                        if (lo_need) begin
                            state     <= ST_CPU_LO;
                            ram_req   <= 1'b1;
                            ram_we    <= cpu_we;
                            ram_addr  <= req_hw_lo;
                            ram_be    <= cpu_be[1:0];
                            ram_wdata <= cpu_wdata[15:0];
                        end else if (hi_need) begin
                            state     <= ST_CPU_HI;
                            ram_req   <= 1'b1;
                            ram_we    <= cpu_we;
                            ram_addr  <= req_hw_hi;
                            ram_be    <= cpu_be[3:2];
                            ram_wdata <= cpu_wdata[31:16];
                        end else begin
                            state   <= ST_CPU_ACK;
                            cpu_ack <= 1'b1;
                        end
                    end
                end

                ST_LD_WR: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end

                ST_CPU_LO: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        if (!ram_we) begin
                            cpu_rdata[15:0] <= ram_rdata;
                        end
                        if (hi_pend) begin
                            state <= ST_CPU_HI;
                        end else begin
                            state   <= ST_CPU_ACK;
                            cpu_ack <= 1'b1;
                        end
                    end
                end

                // Entered with ram_req low after a low half: raise the high op one cycle later
                ST_CPU_HI: begin
                    if (!ram_req) begin
                        ram_req   <= 1'b1;
                        ram_we    <= cur_we;
                        ram_addr  <= cur_hw_hi;
                        ram_be    <= cur_be_hi;
                        ram_wdata <= cur_wdata_hi;
                    end else if (ram_ack) begin
                        ram_req <= 1'b0;
                        if (!ram_we) begin
                            cpu_rdata[31:16] <= ram_rdata;
                        end
                        state   <= ST_CPU_ACK;
                        cpu_ack <= 1'b1;
                    end
                end

                ST_CPU_ACK: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state   <= ST_IDLE;
                    ram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Scoreboard bench for sdram_port_arb: stimulus pushes expected SDRAM ops and
// CPU completions into queues, monitors pop and compare when the DUT presents
// ram_req rising edges or cpu_ack pulses. An SDRAM responder model acks each
// request after a programmable number of cycles.
// Works with or without SDRAM_ARB_ROM_WP_EN defined.
module tb_sdram_port_arb;

    localparam int RAM_AW = 24;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              ld_active;
    logic              ld_wr;
    logic [24:0]       ld_addr;
    logic [15:0]       ld_data;
    logic              ld_wait;
    logic              cpu_req;
    logic              cpu_we;
    logic [RAM_AW:0]   cpu_addr;
    logic [3:0]        cpu_be;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              ram_req;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [1:0]        ram_be;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;
    logic              ram_ack;

    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [1:0]        be;
        logic [15:0]       wdata;
        logic              is_ld;
    } ram_op_t;

    typedef struct packed {
        logic        chk;
        logic [31:0] rdata;
    } cpu_exp_t;

    ram_op_t  exp_ram[$];
    cpu_exp_t exp_cpu[$];
    int total = 0;
    int bad = 0;
    int ack_count = 0;
    int lat = 1;

    sdram_port_arb dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ld_active (ld_active),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_wait   (ld_wait),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_be    (cpu_be),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ram(input logic we, input logic [RAM_AW-1:0] a, input logic [1:0] be,
                            input logic [15:0] d, input logic is_ld);
        ram_op_t o;
        o.we = we; o.addr = a; o.be = be; o.wdata = d; o.is_ld = is_ld;
        exp_ram.push_back(o);
    endtask

    task automatic push_cpu(input logic chk, input logic [31:0] rd);
        cpu_exp_t c;
        c.chk = chk; c.rdata = rd;
        exp_cpu.push_back(c);
    endtask

    function automatic logic [15:0] rd_model(input logic [RAM_AW-1:0] a);
        case (a)
            24'h000080: return 16'hBEEF;
            24'h000081: return 16'hDEAD;
            default:    return a[15:0] ^ 16'hA5A5;
        endcase
    endfunction

    // SDRAM responder: ack after lat cycles of a held request
    initial begin
        int cnt;
        cnt = 0;
        ram_ack = 1'b0;
        ram_rdata = 16'h0000;
        forever begin
            @(posedge clk_sys); #1;
            ram_ack = 1'b0;
            if (ram_req) begin
                cnt++;
                if (cnt >= lat) begin
                    ram_ack = 1'b1;
                    ram_rdata = rd_model(ram_addr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: compare each new SDRAM op and each CPU completion against the queues
    initial begin
        logic prev_req;
        ram_op_t cap;
        ram_op_t e;
        cpu_exp_t ce;
        prev_req = 1'b0;
        cap = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                prev_req = 1'b0;
            end else begin
                if (ram_req && !prev_req) begin
                    cap.we = ram_we; cap.addr = ram_addr; cap.be = ram_be; cap.wdata = ram_wdata; cap.is_ld = 1'b0;
                    if (exp_ram.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_ram_req: got addr %0h we %0b, required none", ram_addr, ram_we);
                    end else begin
                        e = exp_ram.pop_front();
                        check("ram_we", ram_we, e.we);
                        check("ram_addr", ram_addr, e.addr);
                        check("ram_be", ram_be, e.be);
                        if (e.we) check("ram_wdata", ram_wdata, e.wdata);
                        if (e.is_ld) check("ld_wait_inflight", ld_wait, 1);
                    end
                end
                if (ram_req && ram_ack)
                    check("ram_stable", {ram_we, ram_addr, ram_be, ram_wdata},
                          {cap.we, cap.addr, cap.be, cap.wdata});
                if (cpu_ack) begin
                    ack_count++;
                    if (exp_cpu.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_cpu_ack: got ack rdata %0h, required none", cpu_rdata);
                    end else begin
                        ce = exp_cpu.pop_front();
                        if (ce.chk) check("cpu_rdata", cpu_rdata, ce.rdata);
                    end
                end
                prev_req = ram_req;
            end
        end
    end

    // Loader protocol: a strobe while the buffer is full is a violation
    always @(negedge clk_sys) begin
        if (reset_n && ld_wr) begin
            assert (!ld_wait) else begin
                total++; bad++;
                $display("FAIL ld_wr_while_full: got ld_wait=1, required 0");
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys); #1;
    endtask

    task automatic ld_write(input logic [24:0] a, input logic [15:0] d);
        int n;
        n = 0;
        while (ld_wait && n < 200) begin tick(); n++; end
        if (ld_wait) begin
            total++; bad++;
            $display("FAIL ld_wait_timeout: got ld_wait=1 after %0d cycles, required 0", n);
        end
        ld_addr = a; ld_data = d; ld_wr = 1'b1;
        tick();
        ld_wr = 1'b0;
        @(negedge clk_sys);
        check("ld_wait_after_wr", ld_wait, 1);
    endtask

    task automatic cpu_txn(input logic we, input logic [24:0] a, input logic [3:0] be,
                           input logic [31:0] wd, output int n);
        cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = wd; cpu_req = 1'b1;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!cpu_ack && n < 200);
        if (!cpu_ack) begin
            total++; bad++;
            $display("FAIL cpu_ack_timeout: got no ack in %0d cycles, required ack", n);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_ram.size() != 0 || exp_cpu.size() != 0 || ram_req || ld_wait) && n < 500) begin
            tick(); n++;
        end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d ram / %0d cpu pending, required 0", exp_ram.size(), exp_cpu.size());
        end
    endtask

    initial begin
        int n;
        int base;
        reset_n = 1'b0; ld_active = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("reset_outputs", {ram_req, ram_we, ram_addr, ram_be, ram_wdata, cpu_ack, ld_wait}, 0);
        check("reset_rdata", cpu_rdata, 0);
        tick(); reset_n = 1'b1; tick();

        // Loader burst: four halfwords at byte 0,2,4,6
        lat = 5; ld_active = 1'b1;
        for (int i = 0; i < 4; i++) push_ram(1'b1, RAM_AW'(i), 2'b11, 16'((i + 1) * 16'h1111), 1'b1);
        for (int i = 0; i < 4; i++) ld_write(25'(2 * i), 16'((i + 1) * 16'h1111));
        drain();
        ld_active = 1'b0;
        tick();

        // Full 32-bit read split in two halves
        lat = 2;
        push_ram(1'b0, 24'h80, 2'b11, 16'h0, 1'b0);
        push_ram(1'b0, 24'h81, 2'b11, 16'h0, 1'b0);
        push_cpu(1'b1, 32'hDEADBEEF);
        cpu_txn(1'b0, 25'h100, 4'hF, 32'h0, n);

        // High-half-only write and empty-enable accesses
        push_ram(1'b1, 24'h5, 2'b11, 16'hCAFE, 1'b0);
        push_cpu(1'b0, 32'h0);
        cpu_txn(1'b1, 25'h8, 4'b1100, 32'hCAFE_1234, n);
        push_cpu(1'b0, 32'h0);
        cpu_txn(1'b1, 25'h10, 4'b0000, 32'h5A5A_5A5A, n);
        push_cpu(1'b1, 32'h0);
        cpu_txn(1'b0, 25'h100, 4'b0000, 32'h0, n);

        // Single-half reads; minimum latency with a one-cycle controller
        lat = 1;
        push_ram(1'b0, 24'h82, 2'b11, 16'h0, 1'b0);
        push_cpu(1'b1, 32'h0000_A527);
        cpu_txn(1'b0, 25'h104, 4'b0011, 32'h0, n);
        check("min_latency", n, 3);
        push_ram(1'b0, 24'h83, 2'b11, 16'h0, 1'b0);
        push_cpu(1'b1, 32'hA526_0000);
        cpu_txn(1'b0, 25'h104, 4'b1100, 32'h0, n);
        drain();

        // Loader write arriving mid-CPU access waits for the high half
        lat = 4;
        push_ram(1'b0, 24'h80, 2'b11, 16'h0, 1'b0);
        push_ram(1'b0, 24'h81, 2'b11, 16'h0, 1'b0);
        push_ram(1'b1, 24'h8, 2'b11, 16'h5555, 1'b1);
        push_cpu(1'b1, 32'hDEADBEEF);
        fork
            cpu_txn(1'b0, 25'h100, 4'hF, 32'h0, n);
            begin
                int k;
                k = 0;
                do begin @(negedge clk_sys); k++; end while (!ram_req && k < 50);
                ld_active = 1'b1;
                ld_write(25'h10, 16'h5555);
            end
        join
        drain();

        // CPU request while the loader is active is never started
        base = ack_count;
        cpu_we = 1'b0; cpu_addr = 25'h100; cpu_be = 4'hF; cpu_req = 1'b1;
        repeat (20) tick();
        check("no_ack_while_ld_active", ack_count, base);
        cpu_req = 1'b0; tick();
        ld_active = 1'b0; tick();

        // Reset during the high half abandons the op
        lat = 8;
        push_ram(1'b0, 24'h80, 2'b11, 16'h0, 1'b0);
        push_ram(1'b0, 24'h81, 2'b11, 16'h0, 1'b0);
        cpu_we = 1'b0; cpu_addr = 25'h100; cpu_be = 4'hF; cpu_req = 1'b1;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!(ram_req && ram_addr == 24'h81) && n < 100);
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL hi_half_timeout: got no high op, required ram_addr 81");
        end
        @(posedge clk_sys); #2;
        reset_n = 1'b0;
        #1;
        check("reset_midop_outputs", {ram_req, ram_we, ram_addr, ram_be, ram_wdata, cpu_ack, ld_wait}, 0);
        check("reset_midop_rdata", cpu_rdata, 0);
        cpu_req = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        lat = 2;
        push_ram(1'b0, 24'h80, 2'b11, 16'h0, 1'b0);
        push_cpu(1'b1, 32'h0000_BEEF);
        cpu_txn(1'b0, 25'h100, 4'b0011, 32'h0, n);

        // BIOS write-protect window boundaries
`ifdef SDRAM_ARB_ROM_WP_EN
        push_cpu(1'b0, 32'h0);
        cpu_txn(1'b1, 25'h20, 4'hF, 32'h1234_5678, n);
        push_cpu(1'b0, 32'h0);
        cpu_txn(1'b1, 25'h1FFFFC, 4'b1100, 32'hABCD_0000, n);
`else
        push_ram(1'b1, 24'h10, 2'b11, 16'h5678, 1'b0);
        push_ram(1'b1, 24'h11, 2'b11, 16'h1234, 1'b0);
        push_cpu(1'b0, 32'h0);
        cpu_txn(1'b1, 25'h20, 4'hF, 32'h1234_5678, n);
        push_ram(1'b1, 24'hFFFFF, 2'b11, 16'hABCD, 1'b0);
        push_cpu(1'b0, 32'h0);
        cpu_txn(1'b1, 25'h1FFFFC, 4'b1100, 32'hABCD_0000, n);
`endif
        push_ram(1'b1, 24'h100000, 2'b11, 16'h9999, 1'b0);
        push_cpu(1'b0, 32'h0);
        cpu_txn(1'b1, 25'h200000, 4'b0011, 32'h0000_9999, n);
        drain();

        repeat (5) tick();
        check("exp_ram_empty", exp_ram.size(), 0);
        check("exp_cpu_empty", exp_cpu.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

endmodule
